// File: rtl/dds_pkg.sv
// dds_pkg: shared types and constants for the DDS LUT loader slice.
//   DDS_ADDR_W / DDS_DATA_W : default LUT address and sample widths
//   mode_t                  : load source (host stream or built-in generator)
//   state_t                 : loader FSM states
//   SYNC_STEP               : step value that realigns the DDS write address
package dds_pkg;

    localparam int          DDS_ADDR_W = 12;
    localparam int          DDS_DATA_W = 8;
    localparam logic [31:0] SYNC_STEP  = 32'h1;

    typedef enum logic [1:0] {
        MODE_HOST = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dds_wavegen.sv
// dds_wavegen: combinational waveform byte for the built-in generator modes.
//   mode   in  mode_t   selected generator (MODE_HOST yields 0, unused by the loader)
//   index  in  ADDR_W   LUT address being written
//   sample out DATA_W   signed two's-complement sample for that address
// Saw and triangle span the full code range; square sits at +/- full scale
// (symmetric, so 0x80 is never produced).
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
) (
    input  mode_t             mode,
    input  logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] sample
);

    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] POS_FS   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_FS   = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    logic              upper_half;
    logic [DATA_W-2:0] saw_low;
    logic [DATA_W-1:0] tri_ramp;
    logic              unused_lsbs;

    assign upper_half  = index[ADDR_W-1];
    assign saw_low     = index[ADDR_W-2 -: DATA_W-1];
    assign tri_ramp    = index[ADDR_W-2 -: DATA_W];
    // Triangle slope uses address bits down to ADDR_W-DATA_W-1; the rest are don't-care.
    assign unused_lsbs = ^index[ADDR_W-DATA_W-2:0];

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        sample = '0;
        case (mode)
            MODE_SAW:  sample = {~upper_half, saw_low};
            // Offset-binary ramp flipped into two's complement by toggling the sign bit.
            MODE_TRI:  sample = (upper_half ? ~tri_ramp : tri_ramp) ^ SIGN_BIT;
            MODE_SQR:  sample = upper_half ? NEG_FS : POS_FS;
            MODE_HOST: sample = '0;
        endcase
    end

endmodule

// File: rtl/dds_lut_loader.sv
// dds_lut_loader: streams a full LUT image into the DDS config port.
//   clk, reset         system clock; asynchronous active-high reset
//   start, abort       one-cycle pulses: begin / cancel a load
//   mode               load source, sampled on start (see mode_t)
//   s_data/s_valid/s_ready  host byte stream (valid/ready)
//   step_in/step_out   user phase step in; step driven to the DDS
//   cfg/cfg_ce         LUT byte and write strobe to the DDS
//   busy, done         load in progress; one-cycle pulse with the last byte
//   lut_valid          a complete image has been written since reset/abort
// The DDS clears its write address whenever it sees a nonzero step with no
// write, so the one-cycle SYNC step aligns it to address 0 before LOAD,
// where step is held at 0 so the address only moves on cfg_ce.
module dds_lut_loader
    import dds_pkg::*;
#(
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       step_in,
    output logic [31:0]       step_out,
    output logic [DATA_W-1:0] cfg,
    output logic              cfg_ce,
    output logic              busy,
    output logic              done,
    output logic              lut_valid
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    state_t            state, next_state;
    mode_t             mode_q;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] gen_sample;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              lut_valid_next;
    logic [31:0]       step_next;

    dds_wavegen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wavegen (
        .mode   (mode_q),
        .index  (index),
        .sample (gen_sample)
    );

    assign wr_data = (mode_q == MODE_HOST) ? s_data : gen_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        wr_en          = 1'b0;
        lut_valid_next = lut_valid;
        step_next      = '0;

        case (state)
            IDLE: begin
                // start outranks a same-cycle abort; abort means nothing here.
                if (start) begin
                    next_state     = SYNC;
                    lut_valid_next = 1'b0;
                end
            end
            SYNC: next_state = abort ? IDLE : LOAD;
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    // s_ready is registered, so it is the accept decision for this cycle.
                    wr_en = (mode_q == MODE_HOST) ? (s_valid && s_ready) : 1'b1;
                    if (wr_en && (index == LAST_INDEX)) begin
                        next_state     = DONE;
                        lut_valid_next = 1'b1;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        case (next_state)
            SYNC:    step_next = SYNC_STEP;
            LOAD:    step_next = '0;
            default: step_next = lut_valid_next ? step_in : '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_HOST;
            index     <= '0;
            cfg       <= '0;
            cfg_ce    <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lut_valid <= 1'b0;
            step_out  <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q <= mode_t'(mode);
                index  <= '0;
            end else if (wr_en) begin
                index <= index + ADDR_W'(1);
            end

            cfg_ce <= wr_en;
            if (wr_en) begin
                cfg <= wr_data;
            end

            // Drops on the edge that accepts the final byte, so exactly 2**ADDR_W beats are taken.
            s_ready   <= (next_state == LOAD) && (mode_q == MODE_HOST);
            busy      <= (next_state == SYNC) || (next_state == LOAD);
            done      <= (next_state == DONE);
            lut_valid <= lut_valid_next;
            step_out  <= step_next;
        end
    end

endmodule
